frontmon_trace: RTL

Trace-capture stage sitting directly downstream of the DMB front-panel monitor multiplexer. Every clock it records the 16-bit multiplexed monitor word (MULTOUT) into a circular buffer. It arms on command, triggers on a masked pattern match or a forced strobe, and captures a programmable number of post-trigger words. The frozen record is then read out oldest-first through a simple pop interface, giving a logic-analyser view of whatever MODECODE currently routes to the front panel.

---
 rtl/frontmon_trace_pkg.sv | 23 ++
 rtl/frontmon_tram.sv | 38 +++
 rtl/frontmon_trace.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/frontmon_trace_pkg.sv
// Shared types and helpers for the front-panel monitor trace capture block.
// Holds the capture state encoding, default depth and trigger comparator.
package frontmon_trace_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 6;
  localparam int unsigned WORD_W         = 16;
  localparam int unsigned MODE_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits outside the mask never influence the match.
  function automatic logic trig_match(input logic [WORD_W-1:0] word,
                                      input logic [WORD_W-1:0] mask,
                                      input logic [WORD_W-1:0] val);
    return ((word ^ val) & mask) == '0;
  endfunction

endpackage

// File: rtl/frontmon_tram.sv
// Simple dual-port trace RAM: synchronous write port, registered read port.
// The read register is resettable so the popped-word output starts at zero.
module frontmon_tram #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frontmon_trace.sv
// Logic-analyser style capture of the front-panel monitor word: circular
// buffer, masked/forced trigger, post-trigger count and oldest-first readout.
module frontmon_trace
  import frontmon_trace_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned TMR        = 0
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic [15:0]           MULTOUT,
  input  logic [3:0]            MODECODE,
  input  logic                  ARM,
  input  logic                  FORCE_TRIG,
  input  logic [15:0]           TRIG_MASK,
  input  logic [15:0]           TRIG_VAL,
  input  logic [DEPTH_LOG2-1:0] POSTTRIG,
  input  logic                  RD_EN,
  output logic [15:0]           RD_DATA,
  output logic                  RD_VALID,
  output logic [1:0]            STATE,
  output logic [DEPTH_LOG2:0]   WORDS,
  output logic [3:0]            TRIG_MODE,
  output logic                  MODECHG
);

  localparam int unsigned AW = DEPTH_LOG2;
  localparam int unsigned FW = DEPTH_LOG2 + 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(1 << AW);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam logic [FW-1:0] ONE_F    = FW'(1);

  // All control state lives in one record so it can be voted as a unit.
  typedef struct packed {
    logic [1:0]        state;
    logic [AW-1:0]     wp;
    logic [FW-1:0]     fill;
    logic [AW-1:0]     cnt;
    logic [AW-1:0]     post;
    logic [AW-1:0]     rp;
    logic [FW-1:0]     words;
    logic [MODE_W-1:0] trig_mode;
    logic [MODE_W-1:0] mode_prev;
    logic              modechg;
    logic              rd_valid;
  } ctrl_t;

  ctrl_t         ctrl_d;
  ctrl_t         ctrl_q;
  state_e        state_q;
  state_e        state_d;
  logic          trig_hit;
  logic          read_en;
  logic          capturing;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] wp_inc;
  logic [FW-1:0] fill_inc;

  assign state_q   = state_e'(ctrl_q.state);
  assign trig_hit  = FORCE_TRIG || trig_match(MULTOUT, TRIG_MASK, TRIG_VAL);
  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign read_en   = (state_q == ST_DONE) && RD_EN && (ctrl_q.words != '0);
  assign wp_inc    = ctrl_q.wp + ONE_A;
  assign fill_inc  = (ctrl_q.fill == FILL_MAX) ? ctrl_q.fill : ctrl_q.fill + ONE_F;

  // Control state register, optionally triplicated with a bitwise majority vote.
  if (TMR != 0) begin : g_tmr
    ctrl_t ctrl_a_q;
    ctrl_t ctrl_b_q;
    ctrl_t ctrl_c_q;

    always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
        ctrl_a_q <= '0;
        ctrl_b_q <= '0;
        ctrl_c_q <= '0;
      end else begin
        ctrl_a_q <= ctrl_d;
        ctrl_b_q <= ctrl_d;
        ctrl_c_q <= ctrl_d;
      end
    end

    assign ctrl_q = ctrl_t'((ctrl_a_q & ctrl_b_q) | (ctrl_a_q & ctrl_c_q) |
                            (ctrl_b_q & ctrl_c_q));
  end else begin : g_simplex
    ctrl_t ctrl_r_q;

    always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
        ctrl_r_q <= '0;
      end else begin
        ctrl_r_q <= ctrl_d;
      end
    end

    assign ctrl_q = ctrl_r_q;
  end

  // Next-state logic; ARM restarts from any state and outranks trigger/read.
  always_comb begin
    state_d = state_q;
    if (ARM) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (trig_hit) begin
            state_d = (ctrl_q.post == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (ctrl_q.cnt == ONE_A) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (read_en && (ctrl_q.words == ONE_F)) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output updates.
  always_comb begin
    ctrl_d           = ctrl_q;
    ctrl_d.state     = state_d;
    ctrl_d.rd_valid  = 1'b0;
    ctrl_d.mode_prev = MODECODE;
    ram_we           = 1'b0;
    ram_re           = 1'b0;

    if (ARM) begin
      ctrl_d.wp      = '0;
      ctrl_d.fill    = '0;
      ctrl_d.cnt     = '0;
      ctrl_d.rp      = '0;
      ctrl_d.words   = '0;
      ctrl_d.modechg = 1'b0;
      ctrl_d.post    = POSTTRIG;
    end else if (capturing) begin
      ram_we      = 1'b1;
      ctrl_d.wp   = wp_inc;
      ctrl_d.fill = fill_inc;
      if (MODECODE != ctrl_q.mode_prev) begin
        ctrl_d.modechg = 1'b1;
      end
      if (state_q == ST_ARMED) begin
        if (trig_hit) begin
          ctrl_d.trig_mode = MODECODE;
          ctrl_d.cnt       = ctrl_q.post;
        end
      end else begin
        ctrl_d.cnt = ctrl_q.cnt - ONE_A;
      end
      // Freeze the record: oldest word sits fill entries behind the write pointer.
      if (state_d == ST_DONE) begin
        ctrl_d.words = fill_inc;
        ctrl_d.rp    = wp_inc - fill_inc[AW-1:0];
      end
    end else if (read_en) begin
      ram_re          = 1'b1;
      ctrl_d.rp       = ctrl_q.rp + ONE_A;
      ctrl_d.words    = ctrl_q.words - ONE_F;
      ctrl_d.rd_valid = 1'b1;
    end
  end

  frontmon_tram #(
    .AW (AW),
    .DW (WORD_W)
  ) u_tram (
    .clk   (CLK),
    .rst_n (RST_B),
    .we    (ram_we),
    .waddr (ctrl_q.wp),
    .wdata (MULTOUT),
    .re    (ram_re),
    .raddr (ctrl_q.rp),
    .rdata (RD_DATA)
  );

  assign RD_VALID  = ctrl_q.rd_valid;
  assign STATE     = ctrl_q.state;
  assign WORDS     = ctrl_q.words;
  assign TRIG_MODE = ctrl_q.trig_mode;
  assign MODECHG   = ctrl_q.modechg;

endmodule
